// File: rtl/pipe_mips32_if.sv
// -----------------------------------------------------------------------------
// pipe_mips32_if
// Status bundle exported by the pipe_mips32 core.
//   pc           : current fetch address (word address)
//   halted       : high once a HLT has retired; stays high until reset
//   taken_branch : one-cycle pulse on the edge a branch redirects fetch
// Modports:
//   master : driven by the core
//   slave  : observed by whoever monitors the core
// -----------------------------------------------------------------------------
interface pipe_mips32_if;
  logic [31:0] pc;
  logic        halted;
  logic        taken_branch;

  modport master (output pc, halted, taken_branch);
  modport slave  (input  pc, halted, taken_branch);
endinterface

// File: rtl/pipe_mips32.sv
// -----------------------------------------------------------------------------
// pipe_mips32
// Five-stage (IF, ID, EX, MEM, WB) pipelined 32-bit MIPS-subset core with a
// unified 1024-word memory and a 32-entry register file held inside the block.
// Execution starts at PC 0 after reset and stops when a HLT retires.
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous active-high reset (PC, HALTED, TAKEN_BRANCH and all
//            pipeline registers; register file and memory keep their contents)
//   stat_o : status bundle (pc, halted, taken_branch)
// Internal state Reg_bank, Mem, PC, HALTED and TAKEN_BRANCH is kept under
// those exact names so it can be preloaded and inspected hierarchically.
// -----------------------------------------------------------------------------
module pipe_mips32 (
  input  logic          clk,
  input  logic          rst,
  pipe_mips32_if.master stat_o
);

  typedef enum logic [2:0] {
    T_NOP, T_RR, T_RM, T_LW, T_SW, T_BR, T_HLT
  } itype_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Architectural state
  logic [31:0] Reg_bank [0:31];
  logic [31:0] Mem      [0:1023];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // IF/ID
  logic        if_id_vld_q;
  logic [31:0] if_id_ir_q;
  logic [31:0] if_id_npc_q;

  // ID/EX
  itype_e      id_ex_type_q;
  logic [5:0]  id_ex_op_q;
  logic [4:0]  id_ex_rs_q, id_ex_rt_q, id_ex_dst_q;
  logic        id_ex_wen_q;
  logic [31:0] id_ex_a_q, id_ex_b_q, id_ex_imm_q, id_ex_npc_q;

  // EX/MEM
  itype_e      ex_mem_type_q;
  logic [4:0]  ex_mem_dst_q;
  logic        ex_mem_wen_q;
  logic [31:0] ex_mem_alu_q, ex_mem_b_q;

  // MEM/WB
  itype_e      mem_wb_type_q;
  logic [4:0]  mem_wb_dst_q;
  logic        mem_wb_wen_q;
  logic [31:0] mem_wb_alu_q, mem_wb_lmd_q;

  function automatic itype_e decode(input logic [5:0] op);
    decode = T_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode = T_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     decode = T_RM;
      OP_LW:                                         decode = T_LW;
      OP_SW:                                         decode = T_SW;
      OP_BNEQZ, OP_BEQZ:                             decode = T_BR;
      OP_HLT:                                        decode = T_HLT;
      default:                                       decode = T_NOP;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // ID: decode, register read with WB bypass, load-use detection
  // ---------------------------------------------------------------------------
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm, id_a, id_b, wb_val;
  itype_e      id_type;
  logic        id_reads_rs, id_reads_rt, id_wen;
  logic        stall, fetch_stop, fetch_en;

  assign id_op   = if_id_ir_q[31:26];
  assign id_rs   = if_id_ir_q[25:21];
  assign id_rt   = if_id_ir_q[20:16];
  assign id_rd   = if_id_ir_q[15:11];
  assign id_imm  = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
  assign id_type = if_id_vld_q ? decode(id_op) : T_NOP;

  assign id_reads_rs = (id_type == T_RR) || (id_type == T_RM) || (id_type == T_LW) ||
                       (id_type == T_SW) || (id_type == T_BR);
  assign id_reads_rt = (id_type == T_RR) || (id_type == T_SW);
  assign id_dst      = (id_type == T_RR) ? id_rd : id_rt;
  // Writes to R0 are dropped here, so R0 never appears as a forwarding source.
  assign id_wen      = ((id_type == T_RR) || (id_type == T_RM) || (id_type == T_LW)) &&
                       (id_dst != 5'd0);

  assign wb_val = (mem_wb_type_q == T_LW) ? mem_wb_lmd_q : mem_wb_alu_q;

  always_comb begin
    id_a = Reg_bank[id_rs];
    id_b = Reg_bank[id_rt];
    if (mem_wb_wen_q && (mem_wb_dst_q == id_rs)) id_a = wb_val;
    if (mem_wb_wen_q && (mem_wb_dst_q == id_rt)) id_b = wb_val;
    if (id_rs == 5'd0) id_a = '0;
    if (id_rt == 5'd0) id_b = '0;
  end

  // Loaded data only exists after MEM, so a consumer directly behind a LW
  // waits one cycle and then picks the data up from MEM/WB.
  assign stall = (id_ex_type_q == T_LW) && id_ex_wen_q &&
                 ((id_reads_rs && (id_rs == id_ex_dst_q)) ||
                  (id_reads_rt && (id_rt == id_ex_dst_q)));

  // Fetch stays off while a HLT is anywhere in flight; a taken branch that
  // squashes the HLT overrides this and redirects PC.
  assign fetch_stop = (id_type == T_HLT) || (id_ex_type_q == T_HLT) ||
                      (ex_mem_type_q == T_HLT) || (mem_wb_type_q == T_HLT);

  // ---------------------------------------------------------------------------
  // EX: operand forwarding, ALU, branch resolution
  // ---------------------------------------------------------------------------
  logic [31:0] ex_a, ex_b, ex_alu;
  logic        ex_taken;

  always_comb begin
    ex_a = id_ex_a_q;
    ex_b = id_ex_b_q;
    // EX/MEM carries an address, not data, for a LW, so only ALU producers
    // forward from there.
    if (ex_mem_wen_q && (ex_mem_type_q != T_LW) && (id_ex_rs_q != 5'd0) &&
        (ex_mem_dst_q == id_ex_rs_q))
      ex_a = ex_mem_alu_q;
    else if (mem_wb_wen_q && (id_ex_rs_q != 5'd0) && (mem_wb_dst_q == id_ex_rs_q))
      ex_a = wb_val;
    if (ex_mem_wen_q && (ex_mem_type_q != T_LW) && (id_ex_rt_q != 5'd0) &&
        (ex_mem_dst_q == id_ex_rt_q))
      ex_b = ex_mem_alu_q;
    else if (mem_wb_wen_q && (id_ex_rt_q != 5'd0) && (mem_wb_dst_q == id_ex_rt_q))
      ex_b = wb_val;
  end

  always_comb begin
    ex_alu   = '0;
    ex_taken = 1'b0;
    case (id_ex_type_q)
      T_RR: begin
        case (id_ex_op_q)
          OP_ADD:  ex_alu = ex_a + ex_b;
          OP_SUB:  ex_alu = ex_a - ex_b;
          OP_AND:  ex_alu = ex_a & ex_b;
          OP_OR:   ex_alu = ex_a | ex_b;
          OP_SLT:  ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
          OP_MUL:  ex_alu = ex_a * ex_b;
          default: ex_alu = '0;
        endcase
      end
      T_RM: begin
        case (id_ex_op_q)
          OP_ADDI: ex_alu = ex_a + id_ex_imm_q;
          OP_SUBI: ex_alu = ex_a - id_ex_imm_q;
          OP_SLTI: ex_alu = {31'd0, $signed(ex_a) < $signed(id_ex_imm_q)};
          default: ex_alu = '0;
        endcase
      end
      T_LW, T_SW: ex_alu = ex_a + id_ex_imm_q;
      T_BR: begin
        // NPC already holds branch address + 1.
        ex_alu   = id_ex_npc_q + id_ex_imm_q;
        ex_taken = (id_ex_op_q == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0);
      end
      default: ;
    endcase
  end

  assign fetch_en = !HALTED && !ex_taken && !stall && !fetch_stop;

  // ---------------------------------------------------------------------------
  // Memory and register file (not reset; frozen once halted)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && !HALTED) begin
      if (fetch_en) if_id_ir_q <= Mem[PC[9:0]];
      mem_wb_lmd_q <= Mem[ex_mem_alu_q[9:0]];
      if (ex_mem_type_q == T_SW) Mem[ex_mem_alu_q[9:0]] <= ex_mem_b_q;
      if (mem_wb_wen_q) Reg_bank[mem_wb_dst_q] <= wb_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control and stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      PC            <= '0;
      HALTED        <= 1'b0;
      TAKEN_BRANCH  <= 1'b0;
      if_id_vld_q   <= 1'b0;
      id_ex_type_q  <= T_NOP;
      id_ex_wen_q   <= 1'b0;
      ex_mem_type_q <= T_NOP;
      ex_mem_wen_q  <= 1'b0;
      mem_wb_type_q <= T_NOP;
      mem_wb_wen_q  <= 1'b0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= ex_taken;

      // IF
      if (ex_taken) begin
        PC          <= ex_alu;
        if_id_vld_q <= 1'b0;
      end else if (stall) begin
        // PC and IF/ID hold
      end else if (fetch_stop) begin
        if_id_vld_q <= 1'b0;
      end else begin
        PC          <= PC + 32'd1;
        if_id_npc_q <= PC + 32'd1;
        if_id_vld_q <= 1'b1;
      end

      // ID -> EX
      if (ex_taken || stall) begin
        id_ex_type_q <= T_NOP;
        id_ex_wen_q  <= 1'b0;
        id_ex_rs_q   <= 5'd0;
        id_ex_rt_q   <= 5'd0;
      end else begin
        id_ex_type_q <= id_type;
        id_ex_op_q   <= id_op;
        id_ex_rs_q   <= id_rs;
        id_ex_rt_q   <= id_rt;
        id_ex_dst_q  <= id_dst;
        id_ex_wen_q  <= id_wen;
        id_ex_a_q    <= id_a;
        id_ex_b_q    <= id_b;
        id_ex_imm_q  <= id_imm;
        id_ex_npc_q  <= if_id_npc_q;
      end

      // EX -> MEM
      ex_mem_type_q <= id_ex_type_q;
      ex_mem_dst_q  <= id_ex_dst_q;
      ex_mem_wen_q  <= id_ex_wen_q;
      ex_mem_alu_q  <= ex_alu;
      ex_mem_b_q    <= ex_b;

      // MEM -> WB
      mem_wb_type_q <= ex_mem_type_q;
      mem_wb_dst_q  <= ex_mem_dst_q;
      mem_wb_wen_q  <= ex_mem_wen_q;
      mem_wb_alu_q  <= ex_mem_alu_q;

      // WB
      if (mem_wb_type_q == T_HLT) HALTED <= 1'b1;
    end
  end

  assign stat_o.pc           = PC;
  assign stat_o.halted       = HALTED;
  assign stat_o.taken_branch = TAKEN_BRANCH;

endmodule

// File: tb/tb_pipe_mips32.sv
// -----------------------------------------------------------------------------
// tb_pipe_mips32
// Directed test of pipe_mips32: programs are preloaded hierarchically while
// reset is held, then run for an exact number of edges and the resulting
// architectural state is compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pipe_mips32_if stat_if ();

  pipe_mips32 dut (
    .clk    (clk),
    .rst    (rst),
    .stat_o (stat_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_state();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
    for (int k = 0; k < 32; k++) dut.Reg_bank[k] = k;
  endtask

  // After this, the next rising edge is edge 1.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_base_prog();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = 32'h28010078;  // ADDI R1,R0,120
    dut.Mem[1] = 32'h0c631800;  // OR   R3,R3,R3
    dut.Mem[2] = 32'h20220000;  // LW   R2,0(R1)
    dut.Mem[3] = 32'h0c631800;  // OR   R3,R3,R3
    dut.Mem[4] = 32'h2842002d;  // ADDI R2,R2,45
    dut.Mem[5] = 32'h0c631800;  // OR   R3,R3,R3
    dut.Mem[6] = 32'h24220001;  // SW   R2,1(R1)
    dut.Mem[7] = 32'hfc000000;  // HLT
  endtask

  initial begin
    int tb_hi;

    // ---------------- reset state ----------------
    hold_reset();
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    check("rst_if_pc", stat_if.pc, 32'd0);
    $display("step reset: PC=%0d HALTED=%0b", dut.PC, dut.HALTED);

    // ---------------- base program with dummy ORs ----------------
    clear_state();
    load_base_prog();
    release_reset();
    step(11);
    check("prog_halted_e11", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("prog_halted_e12", {31'd0, dut.HALTED}, 32'd1);
    check("prog_if_halted", {31'd0, stat_if.halted}, 32'd1);
    check("prog_mem120", dut.Mem[120], 32'd85);
    check("prog_mem121", dut.Mem[121], 32'd130);
    check("prog_r1", dut.Reg_bank[1], 32'd120);
    check("prog_r2", dut.Reg_bank[2], 32'd130);
    check("prog_pc", dut.PC, 32'd8);
    $display("step base_prog: Mem[121]=%0d R1=%0d R2=%0d", dut.Mem[121], dut.Reg_bank[1], dut.Reg_bank[2]);

    // ---------------- forwarding (no dummies, one load-use stall) ----------------
    hold_reset();
    clear_state();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = 32'h28010078;  // ADDI R1,R0,120
    dut.Mem[1] = 32'h20220000;  // LW   R2,0(R1)
    dut.Mem[2] = 32'h2842002d;  // ADDI R2,R2,45
    dut.Mem[3] = 32'h24220001;  // SW   R2,1(R1)
    dut.Mem[4] = 32'hfc000000;  // HLT
    release_reset();
    step(9);
    check("fwd_halted_e9", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("fwd_halted_e10", {31'd0, dut.HALTED}, 32'd1);
    check("fwd_mem120", dut.Mem[120], 32'd85);
    check("fwd_mem121", dut.Mem[121], 32'd130);
    check("fwd_r1", dut.Reg_bank[1], 32'd120);
    check("fwd_r2", dut.Reg_bank[2], 32'd130);
    $display("step forwarding: Mem[121]=%0d R2=%0d", dut.Mem[121], dut.Reg_bank[2]);

    // ---------------- back-to-back RR ----------------
    hold_reset();
    clear_state();
    dut.Mem[0] = 32'h00221800;  // ADD R3,R1,R2
    dut.Mem[1] = 32'h04612000;  // SUB R4,R3,R1
    dut.Mem[2] = 32'h14632800;  // MUL R5,R3,R3
    dut.Mem[3] = 32'h10233000;  // SLT R6,R1,R3
    dut.Mem[4] = 32'hfc000000;  // HLT
    release_reset();
    step(8);
    check("rr_halted_e8", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("rr_halted_e9", {31'd0, dut.HALTED}, 32'd1);
    check("rr_r3", dut.Reg_bank[3], 32'd3);
    check("rr_r4", dut.Reg_bank[4], 32'd2);
    check("rr_r5", dut.Reg_bank[5], 32'd9);
    check("rr_r6", dut.Reg_bank[6], 32'd1);
    $display("step rr: R3=%0d R4=%0d R5=%0d R6=%0d", dut.Reg_bank[3], dut.Reg_bank[4],
             dut.Reg_bank[5], dut.Reg_bank[6]);

    // ---------------- taken BEQZ ----------------
    hold_reset();
    clear_state();
    dut.Reg_bank[1] = 32'd0;
    dut.Reg_bank[9] = 32'd0;
    dut.Mem[0] = 32'h38200002;  // BEQZ R1,+2
    dut.Mem[1] = 32'h28070005;  // ADDI R7,R0,5
    dut.Mem[2] = 32'h28080006;  // ADDI R8,R0,6
    dut.Mem[3] = 32'h28090009;  // ADDI R9,R0,9
    dut.Mem[4] = 32'hfc000000;  // HLT
    release_reset();
    step(2);
    check("beqz_tb_e2", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    step(1);
    check("beqz_tb_e3", {31'd0, dut.TAKEN_BRANCH}, 32'd1);
    check("beqz_if_tb_e3", {31'd0, stat_if.taken_branch}, 32'd1);
    check("beqz_pc_e3", dut.PC, 32'd3);
    step(1);
    check("beqz_tb_e4", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    step(4);
    check("beqz_halted_e8", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("beqz_halted_e9", {31'd0, dut.HALTED}, 32'd1);
    check("beqz_r7", dut.Reg_bank[7], 32'd7);
    check("beqz_r8", dut.Reg_bank[8], 32'd8);
    check("beqz_r9", dut.Reg_bank[9], 32'd9);
    $display("step beqz: R7=%0d R8=%0d R9=%0d", dut.Reg_bank[7], dut.Reg_bank[8], dut.Reg_bank[9]);

    // ---------------- not-taken BNEQZ ----------------
    hold_reset();
    clear_state();
    dut.Reg_bank[1] = 32'd0;
    dut.Reg_bank[9] = 32'd0;
    dut.Mem[0] = 32'h34200002;  // BNEQZ R1,+2
    dut.Mem[1] = 32'h28070005;
    dut.Mem[2] = 32'h28080006;
    dut.Mem[3] = 32'h28090009;
    dut.Mem[4] = 32'hfc000000;
    release_reset();
    tb_hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (dut.TAKEN_BRANCH) tb_hi++;
    end
    check("bneqz_tb_count", tb_hi, 32'd0);
    check("bneqz_halted_e8", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("bneqz_halted_e9", {31'd0, dut.HALTED}, 32'd1);
    check("bneqz_r7", dut.Reg_bank[7], 32'd5);
    check("bneqz_r8", dut.Reg_bank[8], 32'd6);
    check("bneqz_r9", dut.Reg_bank[9], 32'd9);
    $display("step bneqz: R7=%0d R8=%0d R9=%0d", dut.Reg_bank[7], dut.Reg_bank[8], dut.Reg_bank[9]);

    // ---------------- R0 handling and HALT freeze ----------------
    hold_reset();
    clear_state();
    dut.Reg_bank[0] = 32'h55;   // storage content must never be seen as an operand
    dut.Mem[0] = 32'h28000007;  // ADDI R0,R0,7
    dut.Mem[1] = 32'h00000800;  // ADD  R1,R0,R0
    dut.Mem[2] = 32'hfc000000;  // HLT
    dut.Mem[3] = 32'h28020001;  // ADDI R2,R0,1
    release_reset();
    step(6);
    check("r0_halted_e6", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("r0_halted_e7", {31'd0, dut.HALTED}, 32'd1);
    check("r0_r1", dut.Reg_bank[1], 32'd0);
    check("r0_r2", dut.Reg_bank[2], 32'd2);
    check("r0_reg0", dut.Reg_bank[0], 32'h55);
    check("r0_pc_e7", dut.PC, 32'd3);
    step(5);
    check("r0_pc_frozen", dut.PC, 32'd3);
    check("r0_if_pc_frozen", stat_if.pc, 32'd3);
    check("r0_halted_held", {31'd0, dut.HALTED}, 32'd1);
    check("r0_r2_frozen", dut.Reg_bank[2], 32'd2);
    check("r0_mem3_frozen", dut.Mem[3], 32'h28020001);
    check("r0_mem0_frozen", dut.Mem[0], 32'h28000007);
    $display("step r0_halt: R1=%0d R2=%0d PC=%0d", dut.Reg_bank[1], dut.Reg_bank[2], dut.PC);

    // ---------------- mid-run reset while a SW sits in EX/MEM ----------------
    hold_reset();
    clear_state();
    load_base_prog();
    release_reset();
    step(9);
    rst = 1'b1;
    step(1);
    check("mid_pc", dut.PC, 32'd0);
    check("mid_halted", {31'd0, dut.HALTED}, 32'd0);
    check("mid_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    check("mid_store_dropped", dut.Mem[121], 32'd0);
    release_reset();
    step(11);
    check("mid_halted_e11", {31'd0, dut.HALTED}, 32'd0);
    step(1);
    check("mid_halted_e12", {31'd0, dut.HALTED}, 32'd1);
    check("mid_mem120", dut.Mem[120], 32'd85);
    check("mid_mem121", dut.Mem[121], 32'd130);
    check("mid_r1", dut.Reg_bank[1], 32'd120);
    check("mid_r2", dut.Reg_bank[2], 32'd130);
    $display("step mid_reset: Mem[121]=%0d R1=%0d R2=%0d", dut.Mem[121], dut.Reg_bank[1], dut.Reg_bank[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mips32.md
# pipe_mips32

Five-stage pipelined 32-bit MIPS-subset processor core (IF, ID, EX, MEM, WB) with a unified word-addressed instruction/data memory and a 32×32 register file held inside the block. It runs from PC 0 after reset until a HALT instruction retires. Hardware forwarding and interlocks make results independent of software-inserted dummy instructions. The block has no external data ports: the bench preloads and inspects internal state hierarchically.

## Interface
- No parameters. Memory depth is 1024 words; the register file has 32 entries.
- `clk` input 1: single system clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- Hierarchically visible state, names fixed for the bench:
  - `Reg_bank[0:31]` (32b): register file.
  - `Mem[0:1023]` (32b): unified memory.
  - `PC` (32b).
  - `HALTED` (1b).
  - `TAKEN_BRANCH` (1b).

## Operation
- **Encoding** (`IR[31:26]` opcode, rs=`[25:21]`, rt=`[20:16]`, rd=`[15:11]`, imm=`[15:0]` sign-extended).
- **RR** (rd ← rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, 1/0), MUL 000101 (low 32 bits).
- **RM** (rt ← rs op imm): ADDI 001010, SUBI 001011, SLTI 001100.
- **LW 001000**: rt ← `Mem[rs+imm]`.
- **SW 001001**: `Mem[rs+imm]` ← rt.
- **BNEQZ 001101**: taken if rs≠0.
- **BEQZ 001110**: taken if rs==0.
  - Branch target = branch address + 1 + imm.
- **HLT 111111.** Any other opcode executes as a NOP.
- **Addressing and wrap:** PC and memory are word addressed. The memory index is `addr[9:0]`, so addresses wrap modulo 1024. Arithmetic is 32-bit two's complement and overflow is ignored.
- **R0:** reads as 0. Writes to R0 are discarded.
- **Register file bypass:** a WB write and an ID read of the same register in the same cycle return the new value.
- **Forwarding into EX** (operands A=rs, B=rt, including SW store data and branch test):
  - The EX/MEM ALU result has priority.
  - Then the MEM/WB result (ALU result or loaded data).
  - A source of R0 is never forwarded.
- **Load-use interlock:**
  - Condition: ID holds an instruction reading register r≠0 (rs for all types; rt also for RR and SW) while ID/EX holds LW with rt=r.
  - Action: PC and IF/ID hold, and a bubble is inserted into EX. This costs one cycle.
- **Taken branch:**
  - Resolved in EX. On the next edge, PC ← target and `TAKEN_BRANCH`=1 for exactly that cycle.
  - IF/ID and ID/EX are squashed to bubbles, giving a 2-instruction penalty.
  - Not-taken branches have no penalty.
- **HALT:**
  - When HLT is latched into IF/ID, fetch stops: PC holds and bubbles follow.
  - When HLT reaches WB, `HALTED`←1. After that the whole pipeline, PC, `Reg_bank` and `Mem` freeze until `rst`.
  - If the HLT is squashed by an older taken branch, fetch resumes at the target.
- **Reset:**
  - Sets `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0, and all pipeline registers to bubbles.
  - `Reg_bank` and `Mem` are not reset.
  - Reset mid-run abandons all in-flight instructions; in-flight stores are not performed.

## Timing
- Fetch of instruction k occurs on edge k+1 after reset release, when there are no stalls or branches.
- One stage per edge; WB occurs on edge k+5.
- `Reg_bank` writes are visible after the WB edge. A SW writes `Mem` on its MEM edge.
- Throughput is 1 instruction/cycle. Each load-use stall adds 1 cycle; each taken branch adds 2 cycles.
- `HALTED` rises on the WB edge of HLT. For HLT at address 7 with no stalls, that is edge 12 after reset release.

## Test plan
- **Program:** `Reg_bank[k]`=k, `Mem[120]`=85, `Mem[0..7]` = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000.
  - Required: `Mem[120]`=85, `Mem[121]`=130, R1=120, R2=130, `HALTED`=1 at edge 12.
- **Forwarding:** same program with the dummy ORs removed (5 instructions).
  - Required: identical memory results; the LW→ADDI pair costs 1 stall cycle.
- **Back-to-back RR:** R1=1, R2=2; run ADD R3,R1,R2 then SUB R4,R3,R1 then MUL R5,R3,R3 then SLT R6,R1,R3.
  - Required: R3=3, R4=2, R5=9, R6=1.
- **Branch:** R1=0; run BEQZ R1,+2, then ADDI R7,R0,5, then ADDI R8,R0,6, then ADDI R9,R0,9, then HLT.
  - Required: R7 and R8 unchanged, R9=9, `TAKEN_BRANCH` pulses 1 cycle.
  - Repeat with BNEQZ: required R7=5, R8=6, R9=9.
- **R0 and HALT:** ADDI R0,R0,7; then ADD R1,R0,R0; then HLT; then ADDI R2,R0,1.
  - Required: R1=0, R2 unchanged, `PC` and `Mem` frozen after `HALTED`.
- **Mid-run reset:** assert `rst` for 1 cycle mid-program.
  - Required: `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0; the program re-executes from address 0 with correct final results.
